// File: rtl/key_conditioner.sv
// key_conditioner: input stage ahead of the 8-bit multiplier.
// Synchronises, debounces and edge-detects the active-low pushbuttons
// (bit 0 Reset, bit 1 ClearA_LoadB, bit 2 Run) and synchronises the switch bank.
// Optional feature macro: KEYCOND_AUTOREPEAT_EN (adds held-key auto-repeat on key_press).
module key_conditioner #(
    parameter int NUM_KEYS      = 3,
    parameter int SW_W          = 8,
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [SW_W-1:0]     sw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [SW_W-1:0]     sw_sync
);

    // Debounce counter only needs to reach DB_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);

    // Reject parameter values that would make the counters meaningless.
    if (DB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("key_conditioner: DB_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic [NUM_KEYS-1:0] r_key_s1;
    logic [NUM_KEYS-1:0] r_key_s2;
    logic [SW_W-1:0]     r_sw_s1;
    logic [SW_W-1:0]     r_sw_s2;

    // Two-flop synchronisers; keys reset to the released (high) level so no
    // phantom press is seen while the chain refills after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign sw_sync = r_sw_s2;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic             w_sample;
            logic             w_differs;
            logic             w_accept;
            logic             w_repeat;
            logic [CNT_W-1:0] r_db_cnt;
            logic             r_level;
            logic             r_press;
            logic             r_release;

            // Active-high view of the synchronised key.
            assign w_sample  = ~r_key_s2[gi];
            assign w_differs = (w_sample != r_level);
            // Accept a change once the new level has been seen DB_CYCLES times in a row.
            assign w_accept  = w_differs && (r_db_cnt == DB_MAX);

            // Stability counter: any sample matching the current level restarts the window.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_db_cnt <= '0;
                end else if (!w_differs || w_accept) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            // Debounced level plus press/release pulses, all updated on the same edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_level   <= w_accept ? ~r_level : r_level;
                    r_press   <= (w_accept && !r_level) || w_repeat;
                    r_release <= w_accept && r_level;
                end
            end

`ifdef KEYCOND_AUTOREPEAT_EN
            localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
            localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

            logic [REP_W-1:0] r_rep_cnt;

            // A level edge takes priority over a repeat falling on the same cycle.
            assign w_repeat = r_level && !w_accept && (r_rep_cnt == REP_MAX);

            // Repeat timer runs only while the key is held; restarts on every level edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rep_cnt <= '0;
                end else if (w_accept || !r_level || (r_rep_cnt == REP_MAX)) begin
                    r_rep_cnt <= '0;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end
`else
            // Without auto-repeat each accepted press yields exactly one pulse.
            assign w_repeat = 1'b0;
`endif

            assign key_level[gi]   = r_level;
            assign key_press[gi]   = r_press;
            assign key_release[gi] = r_release;
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DB_CYCLES=4, REPEAT_CYCLES=10.
// Edge numbering: inputs change at a falling edge; the next rising edge is edge 0.
module tb_key_conditioner;

    localparam int NK = 3;
    localparam int SW = 8;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [SW-1:0] sw;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [SW-1:0] sw_sync;

    int checks   = 0;
    int failures = 0;

    key_conditioner #(
        .NUM_KEYS     (NK),
        .SW_W         (SW),
        .DB_CYCLES    (4),
        .REPEAT_CYCLES(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .sw         (sw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_sync    (sw_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_n = '1;
        sw    = 8'h3C;
        settle(3);
        checks++;
        if (key_level !== 3'b000) begin
            failures++; $display("FAIL reset_level got=%b exp=%b", key_level, 3'b000);
        end
        checks++;
        if (key_press !== 3'b000 || key_release !== 3'b000) begin
            failures++; $display("FAIL reset_pulses got press=%b rel=%b exp=000/000", key_press, key_release);
        end
        checks++;
        if (sw_sync !== 8'h00) begin
            failures++; $display("FAIL reset_sw got=%h exp=00", sw_sync);
        end
        sw = 8'h00;
        reset = 1'b0;
        settle(4);
        $display("test_reset done");
    endtask

    task automatic test_sw();
        logic [SW-1:0] vals [2];
        vals[0] = 8'hA5;
        vals[1] = 8'h5A;
        for (int v = 0; v < 2; v++) begin
            logic [SW-1:0] prev;
            prev = sw_sync;
            sw = vals[v];
            tick();
            checks++;
            if (sw_sync !== prev) begin
                failures++; $display("FAIL sw_edge0 got=%h exp=%h", sw_sync, prev);
            end
            tick();
            checks++;
            if (sw_sync !== vals[v]) begin
                failures++; $display("FAIL sw_edge1 got=%h exp=%h", sw_sync, vals[v]);
            end
            checks++;
            if (key_level !== 3'b000 || key_press !== 3'b000) begin
                failures++; $display("FAIL sw_keys got level=%b press=%b exp=000/000", key_level, key_press);
            end
            $display("sw %h -> sw_sync %h", vals[v], sw_sync);
        end
        sw = 8'hA5;
        settle(2);
    endtask

    task automatic test_single_press();
        key_n = 3'b011;
        for (int e = 0; e < 10; e++) begin
            logic [NK-1:0] exp_p, exp_l;
            tick();
            exp_p = (e == 5) ? 3'b100 : 3'b000;
            exp_l = (e >= 5) ? 3'b100 : 3'b000;
            checks++;
            if (key_press !== exp_p) begin
                failures++; $display("FAIL press2_pulse e=%0d got=%b exp=%b", e, key_press, exp_p);
            end
            checks++;
            if (key_level !== exp_l) begin
                failures++; $display("FAIL press2_level e=%0d got=%b exp=%b", e, key_level, exp_l);
            end
            checks++;
            if (key_release !== 3'b000) begin
                failures++; $display("FAIL press2_release e=%0d got=%b exp=000", e, key_release);
            end
        end
        $display("single press key2 level=%b", key_level);
    endtask

    // Key 2 is still held (level=1) on entry.
    task automatic test_reset_mid();
        reset = 1'b1;
        #1;
        checks++;
        if (key_level !== 3'b000 || key_press !== 3'b000 || key_release !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got level=%b press=%b rel=%b exp=000", key_level, key_press, key_release);
        end
        checks++;
        if (sw_sync !== 8'h00) begin
            failures++; $display("FAIL async_reset_sw got=%h exp=00", sw_sync);
        end
        settle(2);
        reset = 1'b0;
        for (int e = 0; e < 10; e++) begin
            logic [NK-1:0] exp_p, exp_l;
            logic [SW-1:0] exp_s;
            tick();
            exp_p = (e == 5) ? 3'b100 : 3'b000;
            exp_l = (e >= 5) ? 3'b100 : 3'b000;
            exp_s = (e >= 1) ? 8'hA5 : 8'h00;
            checks++;
            if (key_press !== exp_p) begin
                failures++; $display("FAIL post_reset_press e=%0d got=%b exp=%b", e, key_press, exp_p);
            end
            checks++;
            if (key_level !== exp_l) begin
                failures++; $display("FAIL post_reset_level e=%0d got=%b exp=%b", e, key_level, exp_l);
            end
            checks++;
            if (sw_sync !== exp_s) begin
                failures++; $display("FAIL post_reset_sw e=%0d got=%h exp=%h", e, sw_sync, exp_s);
            end
        end
        $display("reset mid-operation, key2 re-pressed level=%b", key_level);
    endtask

    task automatic test_release();
        key_n = 3'b111;
        for (int e = 0; e < 10; e++) begin
            logic [NK-1:0] exp_r, exp_l;
            tick();
            exp_r = (e == 5) ? 3'b100 : 3'b000;
            exp_l = (e < 5) ? 3'b100 : 3'b000;
            checks++;
            if (key_release !== exp_r) begin
                failures++; $display("FAIL release2_pulse e=%0d got=%b exp=%b", e, key_release, exp_r);
            end
            checks++;
            if (key_level !== exp_l || key_press !== 3'b000) begin
                failures++;
                $display("FAIL release2_level e=%0d got level=%b press=%b exp=%b/000", e, key_level, key_press, exp_l);
            end
        end
        $display("release key2 level=%b", key_level);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 8; i++) begin
            key_n = {2'b11, 1'((i / 2) % 2)};
            tick();
            checks++;
            if (key_press !== 3'b000 || key_level !== 3'b000) begin
                failures++; $display("FAIL bounce i=%0d got press=%b level=%b exp=000/000", i, key_press, key_level);
            end
        end
        key_n = 3'b110;
        for (int e = 0; e < 9; e++) begin
            logic [NK-1:0] exp_p;
            tick();
            exp_p = (e == 5) ? 3'b001 : 3'b000;
            checks++;
            if (key_press !== exp_p) begin
                failures++; $display("FAIL bounce_press e=%0d got=%b exp=%b", e, key_press, exp_p);
            end
        end
        $display("bounce key0 settled level=%b", key_level);
        key_n = 3'b111;
        settle(10);
    endtask

    task automatic test_simultaneous();
        key_n = 3'b001;
        for (int e = 0; e < 8; e++) begin
            logic [NK-1:0] exp_p;
            tick();
            exp_p = (e == 5) ? 3'b110 : 3'b000;
            checks++;
            if (key_press !== exp_p) begin
                failures++; $display("FAIL simul_press e=%0d got=%b exp=%b", e, key_press, exp_p);
            end
        end
        key_n = 3'b111;
        for (int e = 0; e < 8; e++) begin
            logic [NK-1:0] exp_r;
            tick();
            exp_r = (e == 5) ? 3'b110 : 3'b000;
            checks++;
            if (key_release !== exp_r || key_press !== 3'b000) begin
                failures++;
                $display("FAIL simul_release e=%0d got rel=%b press=%b exp=%b/000", e, key_release, key_press, exp_r);
            end
        end
        $display("simultaneous keys1,2 press/release done");
    endtask

    // Three low cycles is one short of the window: nothing may change.
    // Four low cycles is exactly the window: press at edge 5, release at edge 9.
    task automatic test_glitch_boundary();
        key_n = 3'b011;
        settle(3);
        key_n = 3'b111;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (key_level !== 3'b000 || key_press !== 3'b000 || key_release !== 3'b000) begin
                failures++;
                $display("FAIL glitch3 e=%0d got level=%b press=%b rel=%b exp=000", e, key_level, key_press, key_release);
            end
        end
        key_n = 3'b011;
        for (int e = 0; e < 12; e++) begin
            logic [NK-1:0] exp_p, exp_r;
            if (e == 4) key_n = 3'b111;
            tick();
            exp_p = (e == 5) ? 3'b100 : 3'b000;
            exp_r = (e == 9) ? 3'b100 : 3'b000;
            checks++;
            if (key_press !== exp_p || key_release !== exp_r) begin
                failures++;
                $display("FAIL window4 e=%0d got press=%b rel=%b exp=%b/%b", e, key_press, key_release, exp_p, exp_r);
            end
        end
        $display("glitch/window boundary done");
    endtask

    task automatic test_hold_repeat();
        key_n = 3'b011;
        for (int e = 0; e < 38; e++) begin
            logic [NK-1:0] exp_p;
            tick();
`ifdef KEYCOND_AUTOREPEAT_EN
            exp_p = (e == 5 || e == 15 || e == 25 || e == 35) ? 3'b100 : 3'b000;
`else
            exp_p = (e == 5) ? 3'b100 : 3'b000;
`endif
            checks++;
            if (key_press !== exp_p) begin
                failures++; $display("FAIL hold_press e=%0d got=%b exp=%b", e, key_press, exp_p);
            end
        end
        key_n = 3'b111;
        for (int e = 0; e < 15; e++) begin
            logic [NK-1:0] exp_r;
            tick();
            exp_r = (e == 5) ? 3'b100 : 3'b000;
            checks++;
            if (key_release !== exp_r || key_press !== 3'b000) begin
                failures++;
                $display("FAIL hold_release e=%0d got rel=%b press=%b exp=%b/000", e, key_release, key_press, exp_r);
            end
        end
        $display("hold/repeat key2 done level=%b", key_level);
    endtask

    initial begin
        test_reset();
        test_sw();
        test_single_press();
        test_reset_mid();
        test_release();
        test_bounce();
        test_simultaneous();
        test_glitch_boundary();
        test_hold_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
